// File: rtl/sccb_responder_if.sv
// SCCB wire bundle between a master (bench or bus model) and the responder.
//   sioc     resolved SCCB clock level on the wire
//   siod_in  resolved SCCB data level on the wire
//   siod_oe  responder pull-down enable (1 = pull siod low, 0 = release)
interface sccb_responder_if;
  logic sioc;
  logic siod_in;
  logic siod_oe;

  modport master (output sioc, output siod_in, input siod_oe);
  modport slave  (input sioc, input siod_in, output siod_oe);
endinterface

// File: rtl/sccb_responder.sv
// SCCB (OV7670-style) responder backed by a 256x8 register file.
// Decodes 3-phase writes (ID/sub-address/data) and 2-phase reads (ID/data).
// The sub-address comes from an earlier write or 2-phase write.
// Ports:
//   clk, reset        system clock (>= 8x SCCB bit rate), synchronous active-high reset
//   bus (slave)       sioc / siod_in wire levels in, siod_oe pull-down enable out
//   wr_en/addr/data   one-cycle commit strobe with committed address and byte
//   dbg_addr/dbg_data registered debug read port (1-cycle latency)
//   busy              high from START until STOP
//   id_err            one-cycle pulse on an ID that is neither the write ID nor the read ID
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter bit         ACK_EN   = 1'b1,
  parameter bit         AUTO_INC = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  sccb_responder_if.slave         bus,
  output logic                    wr_en,
  output logic [7:0]              wr_addr,
  output logic [7:0]              wr_data,
  input  logic [7:0]              dbg_addr,
  output logic [7:0]              dbg_data,
  output logic                    busy,
  output logic                    id_err
);

  localparam logic [7:0] WR_ID = {DEV_ADDR, 1'b0};
  localparam logic [7:0] RD_ID = {DEV_ADDR, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_SUB, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  // [0],[1] form the synchronizer, [2] is the history flop for edge detection.
  // Reset to 1 so an idle (pulled-up) bus produces no edge when reset releases.
  logic [2:0] scl_pipe, sda_pipe;
  logic       scl, scl_q, sda, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], bus.sioc};
      sda_pipe <= {sda_pipe[1:0], bus.siod_in};
    end
  end

  assign scl   = scl_pipe[1];
  assign scl_q = scl_pipe[2];
  assign sda   = sda_pipe[1];
  assign sda_q = sda_pipe[2];

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  // sioc must be high in both the current and history sample: a data edge
  // arriving in the same synchronized cycle as a clock edge is just a bit.
  assign start_det = scl & scl_q &  sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q &  sda;

  // bit_cnt: 0..7 data bits received so far, 8 = in 9th (ACK/NA) slot before
  // its rise, 9 = 9th bit sampled, waiting for the fall that closes the byte.
  logic [3:0] bit_cnt;
  logic [6:0] shreg;        // MSBs of the byte being shifted in
  logic [7:0] rx_byte;      // byte completed by the current rise
  logic [7:0] sub_addr;
  logic       ack_pend;     // ACK owed in the 9th slot of the current byte
  logic       rd_active;    // responder is driving a read byte
  logic [6:0] rd_byte;      // low 7 bits of the byte being read out (bit 7 driven at latch)
  logic [2:0] rd_idx;
  logic       byte_done;
  logic       oe;

  logic [7:0] regs [256];

  assign rx_byte = {shreg, sda};
  assign rd_idx  = 3'(4'd7 - bit_cnt);
  assign bus.siod_oe = oe;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state. The phase for the following byte is chosen at the 8th
  // rise; the ACK for the current byte is carried separately in ack_pend.
  always_comb begin
    state_nxt = state;
    byte_done = 1'b0;
    if (start_det) begin
      state_nxt = S_ID;
    end else if (stop_det) begin
      state_nxt = S_IDLE;
    end else if (state != S_IDLE) begin
      if (scl_rise && bit_cnt == 4'd7 && state != S_RDATA) begin
        byte_done = 1'b1;
        case (state)
          S_ID: begin
            if (rx_byte == WR_ID)      state_nxt = S_SUB;
            else if (rx_byte == RD_ID) state_nxt = S_RDATA;
            else                       state_nxt = S_IGNORE;
          end
          S_SUB:   state_nxt = S_WDATA;
          S_WDATA: if (!AUTO_INC) state_nxt = S_IGNORE;
          default: ;
        endcase
      end
      // NA slot of a read: master owns siod, nothing more to say until START/STOP
      if (scl_fall && rd_active && bit_cnt == 4'd8) state_nxt = S_IGNORE;
    end
  end

  // Datapath: bit shifting, commits, ACK and read-data drive
  always_ff @(posedge clk) begin
    if (reset) begin
      oe        <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      id_err    <= 1'b0;
      bit_cnt   <= 4'd0;
      shreg     <= 7'h00;
      sub_addr  <= 8'h00;
      ack_pend  <= 1'b0;
      rd_active <= 1'b0;
      rd_byte   <= 7'h00;
      dbg_data  <= 8'h00;
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else begin
      wr_en    <= 1'b0;
      id_err   <= 1'b0;
      // Sampled before any same-cycle commit lands, so it shows the old value.
      dbg_data <= regs[dbg_addr];

      if (start_det) begin
        // Also the repeated-start path: any partial byte is dropped.
        busy      <= 1'b1;
        oe        <= 1'b0;
        bit_cnt   <= 4'd0;
        ack_pend  <= 1'b0;
        rd_active <= 1'b0;
      end else if (stop_det) begin
        busy      <= 1'b0;
        oe        <= 1'b0;
        bit_cnt   <= 4'd0;
        ack_pend  <= 1'b0;
        rd_active <= 1'b0;
      end else if (state != S_IDLE) begin
        if (scl_rise) begin
          if (bit_cnt < 4'd8) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
          end else if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd9;
          end
          if (byte_done) begin
            case (state)
              S_ID: begin
                if (rx_byte == WR_ID || rx_byte == RD_ID) begin
                  ack_pend <= ACK_EN;
                end else begin
                  ack_pend <= 1'b0;
                  id_err   <= 1'b1;
                end
              end
              S_SUB: begin
                sub_addr <= rx_byte;
                ack_pend <= ACK_EN;
              end
              S_WDATA: begin
                regs[sub_addr] <= rx_byte;
                wr_en          <= 1'b1;
                wr_addr        <= sub_addr;
                wr_data        <= rx_byte;
                ack_pend       <= ACK_EN;
                if (AUTO_INC) sub_addr <= sub_addr + 8'd1;
              end
              default: ack_pend <= 1'b0;
            endcase
          end
        end else if (scl_fall) begin
          if (rd_active) begin
            // Falls after read bits 1..7 present the next bit; the fall after
            // bit 8 releases siod for the master's NA.
            if (bit_cnt >= 4'd1 && bit_cnt <= 4'd7) begin
              oe <= ~rd_byte[rd_idx];
            end else if (bit_cnt == 4'd8) begin
              oe        <= 1'b0;
              rd_active <= 1'b0;
            end
          end else if (bit_cnt == 4'd8) begin
            oe <= ack_pend;
          end else if (bit_cnt == 4'd9) begin
            // End of the 9th bit: byte closed.
            bit_cnt  <= 4'd0;
            ack_pend <= 1'b0;
            oe       <= 1'b0;
            if (state == S_RDATA) begin
              // The ACK-ending fall is also where the read byte starts.
              rd_byte   <= regs[sub_addr][6:0];
              oe        <= ~regs[sub_addr][7];
              rd_active <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
